// File: rtl/zorro_autoconfig_multi.sv
// Zorro III autoconfig responder presenting NUM_BOARDS logical boards as one
// chain in a single physical slot. Each board is configured in turn, stores
// its own base address and gets its own card-cycle select once configured.
module zorro_autoconfig_multi #(
    parameter int unsigned NUM_BOARDS = 2,
    parameter logic [15:0] MFG_ID     = 16'd514,
    parameter logic [7:0]  PROD_ID    = 8'd84,
    parameter logic [31:0] SERIAL     = 32'd14,
    parameter logic [15:0] ROMVEC     = 16'd512,
    parameter logic [3:0]  SIZE_CODE  = 4'b0000
) (
    input  logic                  clk,
    input  logic                  IORST_n,
    input  logic                  Z_FCS_n,
    input  logic                  DOE,
    input  logic                  DS3_n,
    input  logic [1:0]            FC,
    input  logic                  READ,
    input  logic [7:0]            DIN,
    input  logic [7:0]            addrh,
    input  logic [8:2]            addrl,
    input  logic                  BERR_n,
    input  logic                  SENSEZ3,
    input  logic                  CFGIN_n,
    output logic [3:0]            data_out,
    output logic                  config_cycle,
    output logic                  dtack,
    output logic [NUM_BOARDS-1:0] card_cycle,
    output logic [1:0]            cur_board,
    output logic                  cfgout
);

    localparam logic [1:0] LAST = 2'(NUM_BOARDS - 1);

    typedef enum logic {
        ST_CFG,
        ST_DONE
    } state_t;

    state_t                      state, state_nx;
    logic [1:0]                  cur_nx;
    logic [NUM_BOARDS-1:0][7:0]  base;
    logic [NUM_BOARDS-1:0]       configured;
    logic [NUM_BOARDS-1:0]       match;
    logic                        found;
    logic                        adv_pending;
    logic                        wr_lock;
    logic                        done;
    logic                        cycle_end;
    logic [7:0]                  addr_sig;
    logic                        cfg_access;
    logic                        is_base_wr;
    logic                        is_shut_wr;
    logic                        cfg_write;
    logic [7:0]                  prod;
    logic [31:0]                 serial;
    logic                        first;
    logic [3:0]                  rom;

    assign addr_sig  = {addrl[7:2], addrl[8], 1'b0};
    assign cycle_end = Z_FCS_n | !IORST_n | !BERR_n | (FC[1] == FC[0]) | CFGIN_n | !SENSEZ3;
    assign done      = (state == ST_DONE);

    assign cfg_access = !done & config_cycle & DOE & !DS3_n;
    assign is_base_wr = (addr_sig == 8'h44);
    assign is_shut_wr = (addr_sig == 8'h4C);
    // A held strobe keeps acknowledging, but only the first 0x44/0x4C write of
    // a bus cycle is taken so one cycle can never configure two boards.
    assign cfg_write  = cfg_access & !READ & !wr_lock & (is_base_wr | is_shut_wr);

    // Address match against configured boards, lowest index has priority.
    always_comb begin
        match = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_BOARDS; k++) begin
            if (!found && configured[k] && (base[k] == addrh)) begin
                match[k] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // Cycle decode: latch board select or config-space access, hold until cycle end.
    always_ff @(posedge clk or posedge cycle_end) begin
        if (cycle_end) begin
            config_cycle <= 1'b0;
            card_cycle   <= '0;
            wr_lock      <= 1'b0;
        end else begin
            if (!config_cycle && (card_cycle == '0)) begin
                if (found) begin
                    card_cycle <= match;
                end else if (!done && (addrh == 8'hFF)) begin
                    config_cycle <= 1'b1;
                end
            end
            if (cfg_write) begin
                wr_lock <= 1'b1;
            end
        end
    end

    // Per-board base/configured registers and the one-clk advance request.
    always_ff @(posedge clk or negedge IORST_n) begin
        if (!IORST_n) begin
            base        <= '1;
            configured  <= '0;
            adv_pending <= 1'b0;
        end else begin
            adv_pending <= cfg_write;
            if (cfg_write && is_base_wr) begin
                for (int unsigned k = 0; k < NUM_BOARDS; k++) begin
                    if (cur_board == 2'(k)) begin
                        base[k]       <= DIN;
                        configured[k] <= 1'b1;
                    end
                end
            end
        end
    end

    // Chain state register.
    always_ff @(posedge clk or negedge IORST_n) begin
        if (!IORST_n) begin
            state     <= ST_CFG;
            cur_board <= '0;
        end else begin
            state     <= state_nx;
            cur_board <= cur_nx;
        end
    end

    // Chain next state: step to the next board, or finish after the last one.
    always_comb begin
        state_nx = state;
        cur_nx   = cur_board;
        if ((state == ST_CFG) && adv_pending) begin
            if (cur_board == LAST) begin
                state_nx = ST_DONE;
            end else begin
                cur_nx = cur_board + 2'd1;
            end
        end
    end

    // Config-space acknowledge, one pulse per clk while the strobe is held.
    always_ff @(posedge clk or negedge IORST_n) begin
        if (!IORST_n) begin
            dtack <= 1'b0;
        end else begin
            dtack <= cfg_access;
        end
    end

    // Pass the chain on at the end of the bus cycle once every board is done.
    always_ff @(posedge Z_FCS_n or negedge IORST_n) begin
        if (!IORST_n) begin
            cfgout <= 1'b0;
        end else begin
            cfgout <= done;
        end
    end

    // Autoconfig ROM for the board currently being configured.
    always_comb begin
        prod   = PROD_ID + {6'b0, cur_board};
        serial = SERIAL + {30'b0, cur_board};
        first  = (cur_board == 2'd0);
        rom    = 4'hF;
        if (!done) begin
            case (addr_sig)
                8'h00: rom = {2'b10, first && (ROMVEC != 16'd0), cur_board < LAST};
                8'h02: rom = SIZE_CODE;
                8'h04: rom = ~prod[7:4];
                8'h06: rom = ~prod[3:0];
                8'h08: rom = ~4'b0011;
                8'h0A: rom = ~4'b0000;
                8'h10: rom = ~MFG_ID[15:12];
                8'h12: rom = ~MFG_ID[11:8];
                8'h14: rom = ~MFG_ID[7:4];
                8'h16: rom = ~MFG_ID[3:0];
                8'h18: rom = ~serial[31:28];
                8'h1A: rom = ~serial[27:24];
                8'h1C: rom = ~serial[23:20];
                8'h1E: rom = ~serial[19:16];
                8'h20: rom = ~serial[15:12];
                8'h22: rom = ~serial[11:8];
                8'h24: rom = ~serial[7:4];
                8'h26: rom = ~serial[3:0];
                8'h28: rom = first ? ~ROMVEC[15:12] : 4'hF;
                8'h2A: rom = first ? ~ROMVEC[11:8]  : 4'hF;
                8'h2C: rom = first ? ~ROMVEC[7:4]   : 4'hF;
                8'h2E: rom = first ? ~ROMVEC[3:0]   : 4'hF;
                default: rom = 4'hF;
            endcase
        end
    end

    assign data_out = rom;

endmodule

// File: doc/zorro_autoconfig_multi.md
Name: zorro_autoconfig_multi

Overview:
- Parametrised Zorro III autoconfig responder presenting NUM_BOARDS logical boards as one autoconfig chain.
- Boards configure one after another in the same physical slot, each storing its own base address and asserting its own card-cycle select.
- Sits between the Zorro bus front-end (address/strobe decode) and the card's target logic.
- The top level gates data_out onto D31..D28 and drives DTACK.

Parameters:
NUM_BOARDS, 2, logical boards in chain (1..4)
MFG_ID, 16'd514, manufacturer ID, common to all boards
PROD_ID, 8'd84, product ID of board 0; board k reports PROD_ID+k (8-bit wrap)
SERIAL, 32'd14, serial of board 0; board k reports SERIAL+k
ROMVEC, 16'd512, diag ROM vector, board 0 only; 0 = no ROM
SIZE_CODE, 4'b0000, er_type size nibble (reg 0x02), common to all boards

Ports:
clk  in  1  bus-synchronous clock
IORST_n  in  1  async active-low reset
Z_FCS_n  in  1  Zorro full-cycle strobe, low = cycle active
DOE  in  1  data output enable
DS3_n  in  1  data strobe byte 3, low active
FC  in  2  function code
READ  in  1  1 = read, 0 = write
DIN  in  8  D31..D24 write data
addrh  in  8  A31..A24
addrl  in  7  A8..A2
BERR_n  in  1  bus error, low active
SENSEZ3  in  1  1 = Zorro III backplane
CFGIN_n  in  1  chain config-in, low = our turn
data_out  out  4  autoconfig nibble, gated at top
config_cycle  out  1  autoconfig space access in progress
dtack  out  1  one-clk acknowledge pulse
card_cycle  out  NUM_BOARDS  one-hot select of the matched configured board
cur_board  out  2  index of board currently being autoconfigured
cfgout  out  1  CFGOUT to next slot, 1 = whole chain done

Behaviour:
- Reset (IORST_n low, async):
  - cur_board=0, all boards unconfigured.
  - bases=8'hFF, config_cycle=0, card_cycle=0, dtack=0, cfgout=0.
  - Internal state DONE=0.
- addr_sig = {addrl[7:2], addrl[8], 1'b0}.
- cycle_end = Z_FCS_n | !IORST_n | !BERR_n | (FC[1]==FC[0]) | CFGIN_n | !SENSEZ3.
  - cycle_end asynchronously clears config_cycle and card_cycle.
- Each clk rising edge with cycle_end low:
  - If addrh equals the base of configured board k, set card_cycle[k].
  - Lowest index wins if bases are equal.
  - Otherwise, if !DONE and addrh==8'hFF, set config_cycle.
  - Both hold until cycle_end.
- State machine: CFG(k) for k=0..NUM_BOARDS-1, then DONE.
  - In CFG(k), on clk with config_cycle & DOE & !DS3_n: dtack=1 for that clk, otherwise 0.
  - A held strobe re-asserts dtack every clk, as on the existing bus path.
  - Write (!READ) to 0x44: base[k]<=DIN, board k configured, advance.
  - Write to 0x4C: board k shut up (never matches), base unchanged, advance.
  - Write to any other address: dtack only, no state change.
  - Advance = move to CFG(k+1), or to DONE if k==NUM_BOARDS-1.
  - The advance takes effect on the clk after the write. The current cycle keeps config_cycle until cycle_end, so the next board is only visible in a following bus cycle.
  - Reads never change state.
  - In DONE: no config_cycle, no dtack from config space.
- ROM (combinational on addr_sig and cur_board; all values inverted except 0x00/0x02):
  - 0x00 = {2'b10, rv, chain}. rv = (k==0 && ROMVEC!=0). chain = (k<NUM_BOARDS-1).
  - 0x02 = SIZE_CODE.
  - 0x04/06 = ~prod[7:4]/~prod[3:0].
  - 0x08 = ~4'b0011, 0x0A = ~4'b0000.
  - 0x10..0x16 = ~MFG_ID nibbles, MSB first.
  - 0x18..0x26 = ~serial nibbles, MSB first.
  - 0x28..0x2E = ~ROMVEC nibbles for board 0, 4'hF for other boards.
  - All other addresses, and DONE, = 4'hF.
- cfgout latched on rising Z_FCS_n (async clear by reset): cfgout <= DONE.
  - Goes high only at the end of the bus cycle after the last board's config write.
- Reset mid-cycle: everything clears immediately; no partial configuration is retained.

Test Plan:
- NUM_BOARDS=2, reset, read 0x00/0x04/0x06 at addrh=FF → data_out 4'b1011, ~5, ~4. cur_board=0, cfgout=0.
- Write DIN=8'h40 to 0x44; end cycle → cur_board=1, cfgout stays 0. Read 0x00 → 4'b1000; read 0x04/0x06 → ~5/~5 (prod 85). Read 0x28 → 4'hF.
- Write DIN=8'h41 to 0x44; raise Z_FCS_n → cfgout=1. An access at addrh=FF now gives no config_cycle and no dtack.
- After configuration, access addrh=8'h41 → card_cycle=2'b10. Access addrh=8'h40 → 2'b01. BERR_n low mid-cycle → card_cycle clears immediately.
- Shut up board 0 (write 0x4C), configure board 1 at 8'h50 → addrh=FF never selects board 0. addrh=50 → card_cycle=2'b10. cfgout=1.
- Assert IORST_n low mid config write → all outputs at reset values asynchronously. After release, cur_board=0 and bases=FF.
